// File: rtl/alu_mul_div.sv
// Iterative 32x32 multiply / divide unit with HI/LO result registers; divider built only with MDU_DIV_EN.
// Latency: 34 edges from accepting start to done (1 edge for divide-by-zero or divider-less divide).
// Backpressure: start is ignored while busy; there is no queueing.
module alu_mul_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_nxt;
  logic        accept, imm_done;
  logic [4:0]  cnt;
  logic [63:0] work;
  logic [31:0] opnd;
  logic        neg_q;
  logic        sgn;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next, step_next, prod_fix;
  logic [31:0] fix_hi, fix_lo;
`ifdef MDU_DIV_EN
  logic        is_div, neg_r;
  logic [32:0] rem_sh, div_diff;
  logic [63:0] div_next;
  logic [31:0] quo_fix, rem_fix;
`endif

  assign sgn   = ~op[0];
  assign a_mag = (sgn && a[31]) ? (~a + 32'd1) : a;
  assign b_mag = (sgn && b[31]) ? (~b + 32'd1) : b;

  // work holds {partial, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    mul_sum   = {1'b0, work[63:32]} + (work[0] ? {1'b0, opnd} : 33'd0);
    mul_next  = {mul_sum, work[31:1]};
    prod_fix  = neg_q ? (~work + 64'd1) : work;
    step_next = mul_next;
    fix_hi    = prod_fix[63:32];
    fix_lo    = prod_fix[31:0];
`ifdef MDU_DIV_EN
    rem_sh   = {work[63:32], work[31]};
    div_diff = rem_sh - {1'b0, opnd};
    div_next = div_diff[32] ? {rem_sh[31:0], work[30:0], 1'b0}
                            : {div_diff[31:0], work[30:0], 1'b1};
    quo_fix  = neg_q ? (~work[31:0] + 32'd1) : work[31:0];
    rem_fix  = neg_r ? (~work[63:32] + 32'd1) : work[63:32];
    if (is_div) begin
      step_next = div_next;
      fix_hi    = rem_fix;
      fix_lo    = quo_fix;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    imm_done  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
`ifdef MDU_DIV_EN
          imm_done = op[1] && (b == 32'd0);
`else
          imm_done = op[1];
`endif
          if (!imm_done) state_nxt = CALC;
        end
      end
      CALC:    if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi       <= 32'd0;
      lo       <= 32'd0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= 5'd0;
      work     <= 64'd0;
      opnd     <= 32'd0;
      neg_q    <= 1'b0;
`ifdef MDU_DIV_EN
      is_div   <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
      if (accept) begin
        div_zero <= 1'b0;
        done     <= imm_done;
        cnt      <= 5'd0;
        neg_q    <= sgn & (a[31] ^ b[31]);
        if (op[1]) begin
          opnd <= b_mag;
          work <= {32'd0, a_mag};
        end else begin
          opnd <= a_mag;
          work <= {32'd0, b_mag};
        end
`ifdef MDU_DIV_EN
        is_div <= op[1];
        neg_r  <= sgn & a[31];
        if (imm_done) div_zero <= 1'b1;
`endif
      end
      if (state == CALC) begin
        work <= step_next;
        cnt  <= cnt + 5'd1;
      end
      if (state == FIX) begin
        hi   <= fix_hi;
        lo   <= fix_lo;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_mul_div.sv
// Bench for alu_mul_div: vector table, hand-written corner sequences and random ops vs an arithmetic model.
module tb_alu_mul_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        hi_we, lo_we;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi, m_lo;

  alu_mul_div dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Arithmetic reference: full-width products, truncating signed division.
  task automatic ref_op(input logic [1:0] o, input logic [31:0] x, y,
                        input logic [31:0] ch, cl,
                        output logic [31:0] eh, el, output logic edz, output int elat);
    longint      sx, sy;
    logic [63:0] p, q, r;
    eh = ch; el = cl; edz = 1'b0; elat = 34;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      2'b00: begin p = sx * sy; eh = p[63:32]; el = p[31:0]; end
      2'b01: begin p = {32'd0, x} * {32'd0, y}; eh = p[63:32]; el = p[31:0]; end
      default: begin
`ifdef MDU_DIV_EN
        if (y == 32'd0) begin
          edz = 1'b1; elat = 1;
        end else if (o == 2'b10) begin
          q = sx / sy; r = sx % sy; el = q[31:0]; eh = r[31:0];
        end else begin
          el = x / y; eh = x % y;
        end
`else
        elat = 1;
`endif
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, y,
                        input int poke_at, input logic we_same, input string tag);
    logic [31:0] eh, el;
    logic        edz;
    int          elat, n, busy_n;
    if (we_same) begin
      hi_we = 1'b1; wdata = 32'h0000ABCD; m_hi = 32'h0000ABCD;
    end
    ref_op(o, x, y, m_hi, m_lo, eh, el, edz, elat);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; hi_we = 1'b0;
    n = 1; busy_n = busy ? 1 : 0;
    if (we_same) chk({tag, "_same_edge_hi"}, hi, 32'h0000ABCD);
    chk({tag, "_dz_at_accept"}, div_zero, (elat > 1) ? 1'b0 : edz);
    if (elat > 1) chk({tag, "_done_low_after_accept"}, done, 1'b0);
    while (!done && n < 60) begin
      if (n == poke_at) begin
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd7;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h00001234;
      end
      tick();
      if (start) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk({tag, "_busy_we_ignored"}, {hi, lo}, {m_hi, m_lo});
      end
      n++;
      if (busy) busy_n++;
    end
    chk({tag, "_latency"}, n, elat);
    chk({tag, "_busy_cycles"}, busy_n, (elat > 1) ? 33 : 0);
    chk({tag, "_hi_lo"}, {hi, lo}, {eh, el});
    chk({tag, "_div_zero"}, div_zero, edz);
    m_hi = eh; m_lo = el;
  endtask

  vec_t vecs[$];

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    vec_t        v;
    logic [31:0] eh, el;

    reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    m_hi = '0; m_lo = '0;
    #12;
    chk("reset_state", {hi, lo, busy, done, div_zero}, 67'd0);
    reset = 1'b1;
    tick();

    vecs.push_back('{2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0});
    vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0});
    vecs.push_back('{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0});
    vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0});
    vecs.push_back('{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0});
    vecs.push_back('{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
    vecs.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0});
    vecs.push_back('{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0});
    vecs.push_back('{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0});
    vecs.push_back('{2'b11, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0});

    // Back-to-back: each op starts in the cycle its predecessor shows done.
    foreach (vecs[i]) begin
      v = vecs[i];
`ifndef MDU_DIV_EN
      if (v.op[1]) begin v.hi = m_hi; v.lo = m_lo; v.dz = 1'b0; end
`endif
      eh = m_hi; el = m_lo;
      run_op(v.op, v.a, v.b, 0, 1'b0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_table", i), {hi, lo, div_zero}, {v.hi, v.lo, v.dz});
    end

    tick();
    chk("done_one_cycle", done, 1'b0);

    run_op(2'b01, 32'hFFFFFFFF, 32'd2, 10, 1'b0, "busy_start");
    chk("busy_start_result", {hi, lo}, {32'h00000001, 32'hFFFFFFFE});

    tick();
    run_op(2'b00, 32'd2, 32'd3, 0, 1'b1, "same_edge");
    chk("same_edge_result", {hi, lo}, {32'd0, 32'd6});

    tick();
    hi_we = 1'b1; wdata = 32'h11; tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22; tick();
    lo_we = 1'b0;
    chk("preload", {hi, lo}, {32'h11, 32'h22});
    m_hi = 32'h11; m_lo = 32'h22;
    run_op(2'b11, 32'd7, 32'd0, 0, 1'b0, "divu_zero");
    tick(); tick();
`ifdef MDU_DIV_EN
    chk("div_zero_held", {div_zero, done}, {1'b1, 1'b0});
`else
    chk("div_zero_held", {div_zero, done}, {1'b0, 1'b0});
`endif
    run_op(2'b00, 32'd9, 32'd9, 0, 1'b0, "after_dz");

    // Reset in the middle of a multu.
    start = 1'b1; op = 2'b01; a = 32'd123456; b = 32'd789;
    tick();
    start = 1'b0;
    repeat (14) tick();
    chk("mid_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_reset_outputs", {hi, lo, busy, done, div_zero}, 67'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no_done_in_reset", done, 1'b0);
    end
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    tick();
    chk("post_reset_idle", {busy, done}, 2'b00);
    run_op(2'b01, 32'd3, 32'd4, 0, 1'b0, "post_reset");
    chk("post_reset_result", {hi, lo}, {32'd0, 32'd12});

    for (int r = 0; r < 40; r++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: ra = 32'($urandom_range(0, 20));
        1: ra = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, 0, 1'b0, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
